// File: rtl/compa_serial.sv
// compa_serial: multi-cycle magnitude comparator for wide operands.
// One DIGIT-wide slice of the captured operands is compared per clock,
// reusing a single digit-compare stage. Cascade inputs/outputs follow the
// combinational cascade comparator convention (aeqb/agtb/altb).
//
// Optional build macro COMPA_SERIAL_EARLY_EXIT_EN:
//   undefined - fixed latency, LSB digit first, NDIG RUN cycles.
//   defined   - MSB digit first, leaves RUN at the first unequal digit
//               (1..NDIG RUN cycles). Result values match the default build.
module compa_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             aeqbin,
    input  logic             agtbin,
    input  logic             altbin,
    output logic             busy,
    output logic             done,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A cascade input is honoured only when exactly one flag is set;
    // anything else starts from the neutral all-zero state.
    function automatic logic [2:0] clean_cascade(input logic eq_i,
                                                 input logic gt_i,
                                                 input logic lt_i);
        logic [2:0] v;
        v = {eq_i, gt_i, lt_i};
        case (v)
            3'b100, 3'b010, 3'b001: clean_cascade = v;
            default:                clean_cascade = 3'b000;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       run_q, run_d;   // running {eq,gt,lt}
    logic [2:0]       res_q, res_d;   // held result {aeqb,agtb,altb}
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
`ifdef COMPA_SERIAL_EARLY_EXIT_EN
    logic [2:0]       casc_q, casc_d; // cleaned cascade, used if all digits equal
`endif

    // The digit under test always sits at a fixed end of the shifting copies.
`ifdef COMPA_SERIAL_EARLY_EXIT_EN
    assign a_dig_s = a_q[WIDTH-1 -: DIGIT];
    assign b_dig_s = b_q[WIDTH-1 -: DIGIT];
`else
    assign a_dig_s = a_q[DIGIT-1:0];
    assign b_dig_s = b_q[DIGIT-1:0];
`endif

    // Next-state, datapath and output computation for the scan FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        run_d   = run_q;
        res_d   = res_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef COMPA_SERIAL_EARLY_EXIT_EN
        casc_d  = casc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = {CW{1'b0}};
`ifdef COMPA_SERIAL_EARLY_EXIT_EN
                    casc_d  = clean_cascade(aeqbin, agtbin, altbin);
                    run_d   = 3'b000;
`else
                    run_d   = clean_cascade(aeqbin, agtbin, altbin);
`endif
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                cnt_d  = cnt_q + 1'b1;
`ifdef COMPA_SERIAL_EARLY_EXIT_EN
                a_d = a_q << DIGIT;
                b_d = b_q << DIGIT;
                if (a_dig_s > b_dig_s) begin
                    run_d   = 3'b010;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else if (a_dig_s < b_dig_s) begin
                    run_d   = 3'b001;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else if (cnt_q == LAST_DIG) begin
                    run_d   = casc_q;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    run_d   = run_q;
                end
`else
                a_d = a_q >> DIGIT;
                b_d = b_q >> DIGIT;
                if (a_dig_s > b_dig_s) begin
                    run_d = 3'b010;
                end else if (a_dig_s < b_dig_s) begin
                    run_d = 3'b001;
                end else begin
                    run_d = run_q;
                end
                if (cnt_q == LAST_DIG) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
`endif
            end
            ST_DONE: begin
                res_d   = run_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            run_q   <= 3'b000;
            res_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef COMPA_SERIAL_EARLY_EXIT_EN
            casc_q  <= 3'b000;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            run_q   <= run_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef COMPA_SERIAL_EARLY_EXIT_EN
            casc_q  <= casc_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign aeqb = res_q[2];
    assign agtb = res_q[1];
    assign altb = res_q[0];

endmodule

// File: tb/tb_compa_serial.sv
// Directed self-checking bench for compa_serial (WIDTH=16, DIGIT=4).
// Honours COMPA_SERIAL_EARLY_EXIT_EN for the expected done timing.
module tb_compa_serial;

`ifdef COMPA_SERIAL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int NDIG = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        aeqbin, agtbin, altbin;
    logic        busy, done, aeqb, agtb, altb;

    int n_checks;
    int n_pass;

    compa_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .aeqbin(aeqbin), .agtbin(agtbin), .altbin(altbin),
        .busy(busy), .done(done), .aeqb(aeqb), .agtb(agtb), .altb(altb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] va;
        logic [15:0] vb;
        logic [2:0]  cin;   // {eq,gt,lt}
        logic [2:0]  res;   // expected {aeqb,agtb,altb}
        int          erun;  // RUN cycles in the early-exit build
    } vec_t;

    vec_t vecs[6];

    // Single comparison point: count, and report a mismatch.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Launch one compare from IDLE and wait (bounded) for done.
    // lat = edges after the start edge until done is seen; bcnt = busy samples.
    task automatic run_cmp(input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic [2:0] cin, output int lat, output int bcnt);
        a = ta;
        b = tb_v;
        {aeqbin, agtbin, altbin} = cin;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat, bcnt, exp_run;
        exp_run = EARLY ? v.erun : NDIG;
        run_cmp(v.va, v.vb, v.cin, lat, bcnt);
        check_val({v.tag, "_lat"}, lat, exp_run + 1);
        check_val({v.tag, "_busy"}, bcnt, exp_run);
        check_val({v.tag, "_res"}, {aeqb, agtb, altb}, v.res);
        @(posedge clk); #1;
        check_val({v.tag, "_done_drop"}, done, 1'b0);
        check_val({v.tag, "_hold"}, {aeqb, agtb, altb}, v.res);
    endtask

    initial begin
        int d1, d2, saw;
        logic [2:0] r1, r2;

        n_checks = 0;
        n_pass   = 0;
        vecs[0] = '{"gt_eqin",   16'h1234, 16'h1233, 3'b100, 3'b010, 4};
        vecs[1] = '{"eq_ltin",   16'hABCD, 16'hABCD, 3'b001, 3'b001, 4};
        vecs[2] = '{"eq_eqin",   16'hABCD, 16'hABCD, 3'b100, 3'b100, 4};
        vecs[3] = '{"eq_badin",  16'h0F0F, 16'h0F0F, 3'b011, 3'b000, 4};
        vecs[4] = '{"gt_badin",  16'h0F10, 16'h0F0F, 3'b011, 3'b010, 3};
        vecs[5] = '{"eq_5555",   16'h5555, 16'h5555, 3'b100, 3'b100, 4};

        rst_n = 1'b0;
        start = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        {aeqbin, agtbin, altbin} = 3'b000;
        #23;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_res", {aeqb, agtb, altb}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // start held high; operands change during RUN
        a = 16'h0001;
        b = 16'h0002;
        {aeqbin, agtbin, altbin} = 3'b100;
        start = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFF;
        b = 16'h0000;
        d1 = -1;
        d2 = -1;
        r1 = 3'b000;
        r2 = 3'b000;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                if (d1 < 0) begin
                    d1 = i;
                    r1 = {aeqb, agtb, altb};
                end else begin
                    d2 = i;
                    r2 = {aeqb, agtb, altb};
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check_val("b2b_d1", d1, 5);
        check_val("b2b_r1", r1, 3'b001);
        check_val("b2b_d2", d2, 5 + 1 + (EARLY ? 1 : NDIG) + 1);
        check_val("b2b_r2", r2, 3'b010);
        @(posedge clk); #1;

        // asynchronous reset in the 2nd RUN cycle
        a = 16'h1234;
        b = 16'h1233;
        {aeqbin, agtbin, altbin} = 3'b100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        check_val("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_done", done, 1'b0);
        check_val("arst_res", {aeqb, agtb, altb}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw++;
        end
        check_val("arst_no_done", saw, 0);
        run_vec('{"msb_gt", 16'h8000, 16'h7FFF, 3'b100, 3'b010, 1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
